// File: rtl/systolic_row_skewer.sv
// Input skew stage for the systolic array: one vector per beat in, lane i delayed
// i+1 cycles so the west edge sees a diagonal wavefront; tracks tile end and beat count.

module systolic_row_skewer_lane #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic          en_q,
  output logic [DW-1:0] data_q
);
  logic [DEPTH-1:0]         en_pipe;
  logic [DEPTH-1:0][DW-1:0] data_pipe;

  // Bubbles enter as zero data so row_data is 0 whenever row_en is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe   <= '0;
      data_pipe <= '0;
    end else begin
      en_pipe[0]   <= en;
      data_pipe[0] <= en ? data : '0;
      for (int k = 1; k < DEPTH; k++) begin
        en_pipe[k]   <= en_pipe[k-1];
        data_pipe[k] <= data_pipe[k-1];
      end
    end
  end

  assign en_q   = en_pipe[DEPTH-1];
  assign data_q = data_pipe[DEPTH-1];
endmodule

module systolic_row_skewer #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] row_data,
  output logic [ROWS-1:0]            row_en,
  output logic                       tile_done,
  output logic [CNT_WIDTH-1:0]       beat_count,
  output logic                       busy
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  localparam int DRW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t         state_q, state_d;
  logic [DRW-1:0] drain_q, drain_d;
  logic           accept;

  assign accept = in_valid & in_ready;

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    systolic_row_skewer_lane #(.DEPTH(i + 1), .DW(DATA_WIDTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (accept),
      .data   (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .en_q   (row_en[i]),
      .data_q (row_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Drain count reaches 0 exactly when the last beat sits on lane ROWS-1.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = FLUSH;
            drain_d = DRW'(ROWS - 1);
          end else begin
            state_d = STREAM;
          end
        end
      end
      FLUSH: begin
        if (drain_q == '0) state_d = IDLE;
        else               drain_d = drain_q - DRW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q != FLUSH);
  assign busy      = (state_q != IDLE);
  assign tile_done = (state_q == FLUSH) && (drain_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
    end else if (accept) begin
      if (state_q == IDLE)       beat_count <= CNT_WIDTH'(1);
      else if (beat_count != '1) beat_count <= beat_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_systolic_row_skewer.sv
// Bench for systolic_row_skewer: ROWS=4 instance against an edge-indexed history
// model, plus a ROWS=1 / 2-bit counter instance for the degenerate and saturation cases.

module tb_systolic_row_skewer;
  localparam int ROWS = 4;
  localparam int DW   = 8;
  localparam int CW   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0, in_last = 1'b0;
  logic [ROWS*DW-1:0]   in_data = '0;
  logic                 in_ready, tile_done, busy;
  logic [ROWS*DW-1:0]   row_data;
  logic [ROWS-1:0]      row_en;
  logic [CW-1:0]        beat_count;

  logic                 v1 = 1'b0, l1 = 1'b0;
  logic [DW-1:0]        d1 = '0;
  logic                 rdy1, done1, busy1;
  logic [DW-1:0]        rd1;
  logic [0:0]           en1;
  logic [1:0]           cnt1;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  systolic_row_skewer #(.ROWS(ROWS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .row_data(row_data), .row_en(row_en), .tile_done(tile_done),
    .beat_count(beat_count), .busy(busy)
  );

  systolic_row_skewer #(.ROWS(1), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .in_last(l1), .row_data(rd1), .row_en(en1), .tile_done(done1),
    .beat_count(cnt1), .busy(busy1)
  );

  // Model: every edge since reset records what was accepted; lane i after edge e
  // shows whatever was accepted at edge e-i.
  logic               hist_en [0:4095];
  logic [ROWS*DW-1:0] hist_d  [0:4095];
  int                 e;
  int                 last_e;
  bit                 last_set, open, busy_m;
  int                 cnt_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ready_m(input int edge_idx);
    return !(last_set && (edge_idx - last_e) >= 1 && (edge_idx - last_e) <= ROWS);
  endfunction

  task automatic model_reset();
    e = 0; last_e = 0; last_set = 0; open = 0; busy_m = 0; cnt_m = 0;
  endtask

  // Called on the negedge: drive, take one edge, check at the next negedge.
  task automatic tick(input logic v, input logic l, input logic [ROWS*DW-1:0] d);
    bit acc;
    logic [ROWS-1:0]    x_en;
    logic [ROWS*DW-1:0] x_d;
    in_valid = v; in_last = l; in_data = d;
    acc = v && ready_m(e);
    @(posedge clk);
    hist_en[e] = acc;
    hist_d[e]  = d;
    if (acc) begin
      if (!busy_m) cnt_m = 1;
      else if (cnt_m < (1 << CW) - 1) cnt_m++;
      if (l) begin last_set = 1; last_e = e; open = 0; end
      else open = 1;
    end
    busy_m = open || (last_set && e >= last_e && e - last_e <= ROWS - 1);
    @(negedge clk);
    x_en = '0; x_d = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (e - i >= 0 && hist_en[e-i]) begin
        x_en[i] = 1'b1;
        x_d[i*DW +: DW] = hist_d[e-i][i*DW +: DW];
      end
    end
    chk("row_en", 64'(row_en), 64'(x_en));
    chk("row_data", 64'(row_data), 64'(x_d));
    chk("tile_done", 64'(tile_done), 64'(last_set && e == last_e + ROWS - 1));
    chk("in_ready", 64'(in_ready), 64'(ready_m(e + 1)));
    chk("busy", 64'(busy), 64'(busy_m));
    chk("beat_count", 64'(beat_count), 64'(cnt_m));
    e++;
  endtask

  task automatic tick1(input logic v, input logic l, input logic [DW-1:0] d);
    v1 = v; l1 = l; d1 = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_en", 64'(row_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(beat_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-beat tile: one-hot diagonal 1,2,3,4 then tile_done on lane 3's cycle.
    tick(1'b1, 1'b1, 32'h04030201);
    for (int k = 0; k < ROWS + 1; k++) tick(1'b0, 1'b0, '0);

    // Eight back-to-back beats; in_valid stays high through the flush.
    for (int k = 0; k < 8; k++) tick(1'b1, k == 7, $urandom);
    for (int k = 0; k < ROWS + 2; k++) tick(1'b1, 1'b0, $urandom);
    for (int k = 0; k < 2; k++) tick(1'b1, 1'b1, 32'h807f807f);
    for (int k = 0; k < ROWS + 1; k++) tick(1'b0, 1'b0, '0);

    // Bubble pattern: beat, gap, beat+last.
    tick(1'b1, 1'b0, 32'h11223344);
    tick(1'b0, 1'b1, 32'hdeadbeef);
    tick(1'b1, 1'b1, 32'h7f80017f);
    for (int k = 0; k < ROWS + 1; k++) tick(1'b0, 1'b0, '0);

    // Random traffic: sparse valids, occasional last, in_last without in_valid.
    for (int k = 0; k < 400; k++)
      tick(($urandom % 10) < 7, ($urandom % 8) == 0, $urandom);

    // Reset mid-tile: outputs clear asynchronously and the tile never completes.
    tick(1'b1, 1'b0, 32'h01020304);
    tick(1'b1, 1'b0, 32'h05060708);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", 64'(row_en), 64'd0);
    chk("mid_rst_data", 64'(row_data), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < ROWS + 2; k++) tick(1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) tick(1'b1, k == 2, $urandom);
    for (int k = 0; k < ROWS + 2; k++) tick(1'b0, 1'b0, '0);

    // ROWS=1 build: pulse, tile_done and ready-low all in the cycle after the edge.
    tick1(1'b1, 1'b1, 8'h85);
    chk("r1_en", 64'(en1), 64'd1);
    chk("r1_data", 64'(rd1), 64'h85);
    chk("r1_done", 64'(done1), 64'd1);
    chk("r1_ready_low", 64'(rdy1), 64'd0);
    chk("r1_cnt", 64'(cnt1), 64'd1);
    tick1(1'b1, 1'b0, 8'h33);
    chk("r1_flush_no_accept", 64'(en1), 64'd0);
    chk("r1_ready_back", 64'(rdy1), 64'd1);
    chk("r1_idle", 64'(busy1), 64'd0);
    chk("r1_cnt_hold", 64'(cnt1), 64'd1);
    tick1(1'b1, 1'b0, 8'h80);
    chk("r1_cnt_new_tile", 64'(cnt1), 64'd1);
    for (int k = 0; k < 3; k++) tick1(1'b1, 1'b0, 8'h01);
    chk("r1_cnt_sat", 64'(cnt1), 64'd3);
    tick1(1'b1, 1'b1, 8'h7f);
    chk("r1_last_data", 64'(rd1), 64'h7f);
    chk("r1_last_done", 64'(done1), 64'd1);
    chk("r1_cnt_sat_last", 64'(cnt1), 64'd3);
    tick1(1'b0, 1'b0, 8'h00);
    chk("r1_gap_data", 64'(rd1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
